// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sched
// Brief    : 37-tap FIR sharing one multiplier/accumulator across taps.
//            Optional coefficient write port: FIR_SCHED_COEF_WR_EN.
// Revision : 1.0
// ============================================================================
module fir_mac_sched #(
    parameter int TAPS   = 37,
    parameter int IN_WL  = 15,
    parameter int OUT_WL = 20,
    parameter int SHIFT  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_WL-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_WL-1:0] out_data,
`ifdef FIR_SCHED_COEF_WR_EN
    input  logic                     coef_we,
    input  logic [5:0]               coef_addr,
    input  logic signed [IN_WL-1:0]  coef_wdata,
`endif
    output logic                     busy
);

    localparam int c_PTR_W  = $clog2(TAPS);
    localparam int c_PROD_W = 2 * IN_WL;

    typedef logic [c_PTR_W-1:0] ptr_t;
    localparam ptr_t c_LAST = ptr_t'(TAPS - 1);

    // First half of the symmetric default set; the upper half mirrors it.
    localparam int c_HALF [19] = '{
        -38, -137, 0, 241, 120, -331, -351, 338, 690, -178,
        -1114, -267, 1562, 1185, -1964, -3176, 2241, 11639, 16383
    };

    function automatic logic signed [IN_WL-1:0] default_coef(input int idx);
        int m;
        m = (idx > TAPS / 2) ? (TAPS - 1 - idx) : idx;
        return (m >= 0 && m < 19) ? IN_WL'(c_HALF[m]) : '0;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [IN_WL-1:0]   r_hist [TAPS];
    ptr_t                      r_wr_ptr;
    ptr_t                      r_rd_ptr;
    ptr_t                      r_k;
    logic signed [OUT_WL-1:0]  r_acc;
    logic signed [IN_WL-1:0]   w_x;
    logic signed [IN_WL-1:0]   w_coef;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [OUT_WL-1:0]  w_term;

`ifdef FIR_SCHED_COEF_WR_EN
    localparam logic [5:0] c_ADDR_LAST = 6'(TAPS - 1);
    logic signed [IN_WL-1:0] r_coef [TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_coef[i] <= default_coef(i);
        end else if (r_state == S_IDLE && coef_we && coef_addr <= c_ADDR_LAST) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    assign w_coef = r_coef[r_k];
`else
    assign w_coef = default_coef(int'(r_k));
`endif

    // Floor-truncated product, then wrapped into the accumulator width.
    assign w_x    = r_hist[r_rd_ptr];
    assign w_prod = w_x * w_coef;
    assign w_term = OUT_WL'(w_prod >>> SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (r_k == c_LAST) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign out_data = r_acc;

    // Read pointer starts on the newest sample and walks backwards in time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_k      <= '0;
            r_acc    <= '0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_hist[r_wr_ptr] <= in_data;
            r_rd_ptr         <= r_wr_ptr;
            r_wr_ptr         <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + ptr_t'(1);
            r_k              <= '0;
            r_acc            <= '0;
        end else if (r_state == S_MAC) begin
            r_acc    <= r_acc + w_term;
            r_k      <= r_k + ptr_t'(1);
            r_rd_ptr <= (r_rd_ptr == '0) ? c_LAST : r_rd_ptr - ptr_t'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sched
// Brief    : Directed self-checking bench for fir_mac_sched.
// Revision : 1.0
// ============================================================================
module tb_fir_mac_sched;

    localparam int COEF [37] = '{
        -38, -137, 0, 241, 120, -331, -351, 338, 690, -178,
        -1114, -267, 1562, 1185, -1964, -3176, 2241, 11639, 16383,
        11639, 2241, -3176, -1964, 1185, 1562, -267, -1114, -178, 690,
        338, -351, -331, 120, 241, 0, -137, -38
    };

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [14:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [19:0] out_data;
    logic               busy;
`ifdef FIR_SCHED_COEF_WR_EN
    logic               coef_we = 1'b0;
    logic [5:0]         coef_addr = '0;
    logic signed [14:0] coef_wdata = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [14:0] m_hist [37];
    int                 m_ptr;

    always #5 clk = ~clk;

    fir_mac_sched dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef FIR_SCHED_COEF_WR_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Direct-form reference: newest sample at m_ptr, products floored then wrapped.
    function automatic logic signed [19:0] model(input logic signed [14:0] x);
        logic signed [19:0] acc;
        int idx, p;
        m_hist[m_ptr] = x;
        acc = '0;
        for (int k = 0; k < 37; k++) begin
            idx = (m_ptr - k + 37) % 37;
            p   = (int'(m_hist[idx]) * COEF[k]) >>> 10;
            acc = acc + 20'(p);
        end
        m_ptr = (m_ptr + 1) % 37;
        return acc;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 37; i++) m_hist[i] = '0;
        m_ptr = 0;
    endtask

    // Offer one sample, wait for its result; lat counts cycles after the accept edge.
    task automatic send(input logic signed [14:0] x, input int gap, input int rdly,
                        output logic signed [19:0] y, output int lat);
        int n;
        repeat (gap) @(negedge clk);
        in_data   = x;
        in_valid  = 1'b1;
        out_ready = (rdly == 0);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        y = out_data;
        if (rdly > 0) begin
            repeat (rdly) @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic signed [19:0] y;
        logic signed [19:0] exp_y;
        logic signed [14:0] x;
        int lat, n;

        // Reset state
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);

        // Floor truncation of small products
        send(15'sd1, 0, 0, y, lat);
        check("floor_0", y, -1);
        check("floor_lat", lat, 37);
        send(15'sd0, 0, 0, y, lat);
        check("floor_1", y, -1);
        send(15'sd0, 0, 0, y, lat);
        check("floor_2", y, 0);

        // Impulse response reproduces the coefficient set
        do_reset();
        for (int j = 0; j < 37; j++) begin
            send((j == 0) ? 15'sd1024 : 15'sd0, 0, 0, y, lat);
            check($sformatf("impulse_c%0d", j), y, COEF[j]);
            if (j == 0 || j == 36) check($sformatf("impulse_lat%0d", j), lat, 37);
        end

        // Backpressure: result held, input refused
        do_reset();
        @(negedge clk);
        in_data   = 15'sd1024;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 15'sd555;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_lat", n, 37);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, -38);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_valid", out_valid, 0);
        check("bp_xfer_in_ready", in_ready, 1);
        check("bp_xfer_busy", busy, 0);
        send(15'sd0, 0, 0, y, lat);
        check("bp_ignored_input", y, -137);

        // Reset in the middle of the tap walk
        @(negedge clk);
        in_data  = 15'sd1000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        send(15'sd1024, 0, 0, y, lat);
        check("mid_rst_impulse", y, -38);

        // Random full-scale samples against the reference, across pointer wrap
        do_reset();
        for (int i = 0; i < 200; i++) begin
            x     = 15'($urandom_range(0, 32767));
            exp_y = model(x);
            send(x, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), y, lat);
            check($sformatf("rand_%0d", i), y, exp_y);
        end

`ifdef FIR_SCHED_COEF_WR_EN
        // Coefficient write in IDLE takes effect; write during MAC is dropped
        do_reset();
        coef_we    = 1'b1;
        coef_addr  = 6'd0;
        coef_wdata = 15'sd500;
        @(negedge clk);
        coef_we = 1'b0;
        send(15'sd1024, 0, 0, y, lat);
        check("coef_wr_idle", y, 500);
        in_data  = 15'sd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 6'd2;
        coef_wdata = 15'sd7;
        @(negedge clk);
        coef_we = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("coef_mac_out", out_data, -137);
        @(negedge clk);
        send(15'sd0, 0, 0, y, lat);
        check("coef_wr_mac_ignored", y, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
